// File: rtl/rsc_ctrl_seq.sv
// rsc_ctrl_seq: multi-cycle fetch/decode/execute sequencer for the RSC chip.
// Strobes are registered from the next state, so they track the state register exactly.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | reading instruction at PC
// LOADIR | loading IR, bumping PC
// DECODE | latching opcode, halt checks
// EXEC   | ALU latch or memory address setup
// MEM    | load/store handshake
// WB     | register write-back, retire
// HALT   | stopped until reset
module rsc_ctrl_seq #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  opCode,
  input  logic        memReady,
  output logic [2:0]  decEnable,
  output logic        pcInc,
  output logic        addrSel,
  output logic        memRead,
  output logic        memWrite,
  output logic        aluLatch,
  output logic        aluBSel,
  output logic [3:0]  aluOp,
  output logic        regWrite,
  output logic [1:0]  wbSel,
  output logic        busy,
  output logic        halted,
  output logic        illegalOp,
  output logic        timeout,
  output logic [15:0] instrCount
);

  localparam logic [3:0] OP_HALT  = 4'd0;
  localparam logic [3:0] OP_NOT   = 4'd7;
  localparam logic [3:0] OP_ADDI  = 4'd8;
  localparam logic [3:0] OP_SUBI  = 4'd9;
  localparam logic [3:0] OP_MOV   = 4'd10;
  localparam logic [3:0] OP_MOVI  = 4'd11;
  localparam logic [3:0] OP_LOAD  = 4'd12;
  localparam logic [3:0] OP_STORE = 4'd13;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOADIR, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef struct packed {
    logic [2:0] dec;
    logic       pc_inc;
    logic       addr_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       alu_latch;
    logic       alu_bsel;
    logic       reg_wr;
    logic [1:0] wb_sel;
    logic       busy;
    logic       halted;
  } strobes_t;

  function automatic strobes_t decode_out(state_t s, logic [3:0] op);
    strobes_t o;
    o = '0;
    o.busy   = (s != S_IDLE) && (s != S_HALT);
    o.halted = (s == S_HALT);
    case (s)
      S_FETCH: o.mem_rd = 1'b1;
      S_LOADIR: begin
        o.mem_rd = 1'b1;
        o.dec    = 3'b100;
        o.pc_inc = 1'b1;
      end
      S_EXEC: begin
        case (op)
          4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, OP_NOT: o.alu_latch = 1'b1;
          OP_ADDI, OP_SUBI: begin
            o.dec       = 3'b001;
            o.alu_latch = 1'b1;
            o.alu_bsel  = 1'b1;
          end
          OP_LOAD, OP_STORE: begin
            o.dec      = 3'b001;
            o.addr_sel = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        o.dec      = 3'b001;
        o.addr_sel = 1'b1;
        o.mem_rd   = (op == OP_LOAD);
        o.mem_wr   = (op == OP_STORE);
      end
      S_WB: begin
        o.reg_wr = (op != OP_STORE);
        case (op)
          OP_MOVI: begin
            o.wb_sel = 2'b01;
            o.dec    = 3'b001;
          end
          OP_MOV:  o.wb_sel = 2'b10;
          OP_LOAD: begin
            o.wb_sel = 2'b11;
            o.mem_rd = 1'b1;
          end
          default: o.wb_sel = 2'b00;
        endcase
      end
      default: ;
    endcase
    return o;
  endfunction

  state_t             state, state_nxt;
  logic [3:0]         op_q, op_nxt;
  logic [CNT_W-1:0]   wait_cnt, cnt_nxt;
  logic               set_to, set_ill, retire;
  strobes_t           out_q;

  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    set_to    = 1'b0;
    set_ill   = 1'b0;
    retire    = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_FETCH;
      S_FETCH, S_MEM: begin
        if (memReady) begin
          state_nxt = (state == S_FETCH) ? S_LOADIR : S_WB;
        end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_nxt = S_HALT;
          set_to    = 1'b1;
        end
      end
      S_LOADIR: state_nxt = S_DECODE;
      S_DECODE: begin
        op_nxt = opCode;
        if (opCode == OP_HALT) begin
          state_nxt = S_HALT;
        end else if (opCode[3:1] == 3'b111) begin
          state_nxt = S_HALT;
          set_ill   = 1'b1;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: state_nxt = (op_q == OP_LOAD || op_q == OP_STORE) ? S_MEM : S_WB;
      S_WB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      default: state_nxt = S_HALT;
    endcase

    // wait count only accumulates while parked in a memory handshake
    cnt_nxt = wait_cnt;
    if (state_nxt != state) cnt_nxt = '0;
    else if ((state == S_FETCH || state == S_MEM) && !memReady) cnt_nxt = wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      wait_cnt   <= '0;
      out_q      <= '0;
      instrCount <= '0;
      illegalOp  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state    <= state_nxt;
      op_q     <= op_nxt;
      wait_cnt <= cnt_nxt;
      out_q    <= decode_out(state_nxt, op_nxt);
      if (retire)  instrCount <= instrCount + 16'd1;
      if (set_ill) illegalOp  <= 1'b1;
      if (set_to)  timeout    <= 1'b1;
    end
  end

  assign decEnable = out_q.dec;
  assign pcInc     = out_q.pc_inc;
  assign addrSel   = out_q.addr_sel;
  assign memRead   = out_q.mem_rd;
  assign memWrite  = out_q.mem_wr;
  assign aluLatch  = out_q.alu_latch;
  assign aluBSel   = out_q.alu_bsel;
  assign regWrite  = out_q.reg_wr;
  assign wbSel     = out_q.wb_sel;
  assign busy      = out_q.busy;
  assign halted    = out_q.halted;
  assign aluOp     = op_q;

endmodule

// File: tb/tb_rsc_ctrl_seq.sv
// Scoreboard bench for rsc_ctrl_seq: instruction-level model pushes the expected
// per-cycle output bundle; a negedge monitor pops and compares.
module tb_rsc_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst, start, memReady;
  logic [3:0]  opCode;
  logic [2:0]  decEnable;
  logic        pcInc, addrSel, memRead, memWrite, aluLatch, aluBSel, regWrite;
  logic [3:0]  aluOp;
  logic [1:0]  wbSel;
  logic        busy, halted, illegalOp, timeout;
  logic [15:0] instrCount;

  rsc_ctrl_seq dut (
    .clk(clk), .rst(rst), .start(start), .opCode(opCode), .memReady(memReady),
    .decEnable(decEnable), .pcInc(pcInc), .addrSel(addrSel), .memRead(memRead),
    .memWrite(memWrite), .aluLatch(aluLatch), .aluBSel(aluBSel), .aluOp(aluOp),
    .regWrite(regWrite), .wbSel(wbSel), .busy(busy), .halted(halted),
    .illegalOp(illegalOp), .timeout(timeout), .instrCount(instrCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] v;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // reference model state at instruction granularity
  logic [15:0] m_cnt;
  logic [3:0]  m_op;
  logic        m_ill, m_to;

  logic [35:0] act;
  assign act = {decEnable, pcInc, addrSel, memRead, memWrite, aluLatch, aluBSel, aluOp,
                regWrite, wbSel, busy, halted, illegalOp, timeout, instrCount};

  function automatic logic [35:0] mk(input logic [2:0] dec, input logic pci, input logic ads,
                                     input logic mrd, input logic mwr, input logic alat,
                                     input logic absel, input logic rw, input logic [1:0] wb,
                                     input logic bsy, input logic hlt);
    return {dec, pci, ads, mrd, mwr, alat, absel, m_op, rw, wb, bsy, hlt, m_ill, m_to, m_cnt};
  endfunction

  function automatic logic [3:0] rnd_op();
    return 4'($urandom_range(15));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(1));
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h exp %h", e.tag, act, e.v);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  // one clock: record expected outputs for the current cycle, drive inputs for it
  task automatic cyc(input logic [35:0] v, input string tag, input logic mr, input logic [3:0] oc,
                     input logic st, input logic rs, input bit chk);
    exp_t e;
    if (chk) begin
      e.v = v;
      e.tag = tag;
      sb.push_back(e);
    end
    memReady = mr;
    opCode   = oc;
    start    = st;
    rst      = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cnt = '0;
    m_op  = '0;
    m_ill = 1'b0;
    m_to  = 1'b0;
  endtask

  task automatic do_reset();
    cyc('0, "", rnd_bit(), rnd_op(), rnd_bit(), 1'b1, 1'b0);
    model_reset();
    cyc(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "reset", rnd_bit(), rnd_op(), rnd_bit(), 1'b1, 1'b1);
    cyc(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "idle no start", rnd_bit(), rnd_op(), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic go();
    cyc(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "idle start", rnd_bit(), rnd_op(), 1'b1, 1'b0, 1'b1);
  endtask

  // memory handshake lasting `waits` not-ready cycles; 15 consecutive ones abort
  task automatic mem_phase(input int waits, input string tag, input logic [35:0] v, output bit to);
    to = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      cyc(v, tag, (i == waits), rnd_op(), rnd_bit(), 1'b0, 1'b1);
      if (i == 14 && i < waits) begin
        to = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input bit rst_exec,
                           output bit stop);
    bit          to;
    logic [35:0] ex, wb;
    string       t;
    stop = 1'b1;
    t = $sformatf("op%0d", op);
    mem_phase(fw, {"fetch ", t}, mk(3'b000, 0, 0, 1, 0, 0, 0, 0, 2'b00, 1, 0), to);
    if (to) begin
      m_to = 1'b1;
      return;
    end
    cyc(mk(3'b100, 1, 0, 1, 0, 0, 0, 0, 2'b00, 1, 0), {"loadir ", t}, rnd_bit(), rnd_op(), rnd_bit(), 1'b0, 1'b1);
    cyc(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0), {"decode ", t}, rnd_bit(), op, rnd_bit(), 1'b0, 1'b1);
    m_op = op;
    if (op == 4'd0) return;
    if (op >= 4'd14) begin
      m_ill = 1'b1;
      return;
    end
    if (op <= 4'd7)                  ex = mk(3'b000, 0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 0);
    else if (op <= 4'd9)             ex = mk(3'b001, 0, 0, 0, 0, 1, 1, 0, 2'b00, 1, 0);
    else if (op <= 4'd11)            ex = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    else                             ex = mk(3'b001, 0, 1, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    cyc(ex, {"exec ", t}, rnd_bit(), rnd_op(), rnd_bit(), rst_exec, 1'b1);
    if (rst_exec) begin
      model_reset();
      cyc(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "reset hold", rnd_bit(), rnd_op(), rnd_bit(), 1'b1, 1'b1);
      cyc(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "idle after reset", rnd_bit(), rnd_op(), 1'b0, 1'b0, 1'b1);
      return;
    end
    if (op == 4'd12 || op == 4'd13) begin
      mem_phase(mw, {"mem ", t}, mk(3'b001, 0, 1, op == 4'd12, op == 4'd13, 0, 0, 0, 2'b00, 1, 0), to);
      if (to) begin
        m_to = 1'b1;
        return;
      end
    end
    case (op)
      4'd10:   wb = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 0);
      4'd11:   wb = mk(3'b001, 0, 0, 0, 0, 0, 0, 1, 2'b01, 1, 0);
      4'd12:   wb = mk(3'b000, 0, 0, 1, 0, 0, 0, 1, 2'b11, 1, 0);
      4'd13:   wb = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
      default: wb = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 2'b00, 1, 0);
    endcase
    cyc(wb, {"wb ", t}, rnd_bit(), rnd_op(), rnd_bit(), 1'b0, 1'b1);
    m_cnt = m_cnt + 16'd1;
    stop = 1'b0;
  endtask

  task automatic halt_check(input int n);
    for (int i = 0; i < n; i++)
      cyc(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1), "halt", rnd_bit(), rnd_op(), 1'b1, 1'b0, 1'b1);
  endtask

  initial begin : stim
    bit stop;
    model_reset();
    do_reset();
    go();
    run_instr(4'd1, 0, 0, 1'b0, stop);
    run_instr(4'd1, 0, 0, 1'b1, stop);
    go();
    run_instr(4'd1, 0, 0, 1'b0, stop);
    run_instr(4'd11, 0, 0, 1'b0, stop);
    run_instr(4'd8, 0, 0, 1'b0, stop);
    run_instr(4'd10, 1, 0, 1'b0, stop);
    run_instr(4'd12, 0, 3, 1'b0, stop);
    run_instr(4'd13, 2, 0, 1'b0, stop);
    run_instr(4'd7, 14, 0, 1'b0, stop);
    run_instr(4'd13, 0, 14, 1'b0, stop);
    for (int k = 0; k < 40; k++)
      run_instr(4'($urandom_range(13, 1)), $urandom_range(3), $urandom_range(3), 1'b0, stop);
    run_instr(4'd15, 0, 0, 1'b0, stop);
    halt_check(4);

    do_reset();
    go();
    run_instr(4'd3, 0, 0, 1'b0, stop);
    run_instr(4'd14, 1, 0, 1'b0, stop);
    halt_check(2);

    do_reset();
    go();
    run_instr(4'd3, 0, 0, 1'b0, stop);
    run_instr(4'd0, 0, 0, 1'b0, stop);
    halt_check(3);

    do_reset();
    go();
    run_instr(4'd2, 0, 0, 1'b0, stop);
    run_instr(4'd1, 20, 0, 1'b0, stop);
    halt_check(3);

    do_reset();
    go();
    run_instr(4'd12, 0, 20, 1'b0, stop);
    halt_check(3);

    @(negedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
